// File: rtl/rv32i_encoder_stream.sv
// RV32I instruction encoder: descriptor in, checked and address-tagged word out.
// Output side is a 2-entry FIFO; illegal descriptors still occupy a slot as a NOP.
module rv32i_encoder_stream #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_BASE = 32'h0000_0000,
  parameter int          ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_base,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_class,
  input  logic [2:0]          in_funct3,
  input  logic                in_alt,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [31:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_word,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [3:0] C_R      = 4'd0;
  localparam logic [3:0] C_IALU   = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_JAL    = 4'd5;
  localparam logic [3:0] C_JALR   = 4'd6;
  localparam logic [3:0] C_LUI    = 4'd7;
  localparam logic [3:0] C_AUIPC  = 4'd8;
  localparam logic [3:0] C_SYS    = 4'd9;

  logic [31:0] w_raw;
  logic        w_bad;
  logic [31:0] w_word;
  logic [6:0]  w_f7;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;
  logic        w_shift;
  logic        w_push;
  logic        w_pop;

  logic [31:0]         r_word [2];
  logic [ADDR_W-1:0]   r_tag  [2];
  logic [1:0]          r_errq;
  logic                r_wr;
  logic                r_rd;
  logic [1:0]          r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [ERRCNT_W-1:0] r_errcnt;

  assign w_f7    = in_alt ? 7'b0100000 : 7'b0000000;
  assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign w_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    w_raw = NOP;
    w_bad = 1'b0;
    unique case (in_class)
      C_R: begin
        w_raw = {w_f7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
        w_bad = in_alt && !(in_funct3 == 3'b000 || in_funct3 == 3'b101);
      end
      C_IALU: begin
        if (w_shift) begin
          w_raw = {w_f7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          w_bad = (|in_imm[31:5]) || (in_alt && in_funct3 == 3'b001);
        end else begin
          w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          w_bad = in_alt || !w_fit12;
        end
      end
      C_LOAD: begin
        w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        w_bad = !w_fit12 || in_funct3 == 3'b011 ||
                in_funct3 == 3'b110 || in_funct3 == 3'b111;
      end
      C_STORE: begin
        w_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:0], 7'b0100011};
        w_bad = !w_fit12 || in_funct3[2] || (&in_funct3[1:0]);
      end
      C_BRANCH: begin
        w_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], 7'b1100011};
        w_bad = !w_fit13 || in_imm[0] || in_funct3[2:1] == 2'b01;
      end
      C_JAL: begin
        w_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                 in_rd, 7'b1101111};
        w_bad = !w_fit21 || in_imm[0];
      end
      C_JALR: begin
        w_raw = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        w_bad = !w_fit12 || (|in_funct3);
      end
      C_LUI: begin
        w_raw = {in_imm[31:12], in_rd, 7'b0110111};
        w_bad = |in_imm[11:0];
      end
      C_AUIPC: begin
        w_raw = {in_imm[31:12], in_rd, 7'b0010111};
        w_bad = |in_imm[11:0];
      end
      C_SYS: begin
        w_raw = in_alt ? 32'h0010_0073 : 32'h0000_0073;
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
  end

  assign w_word    = w_bad ? NOP : w_raw;
  assign in_ready  = (r_count != 2'd2) && !load_base;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_word  = out_valid ? r_word[r_rd] : NOP;
  assign out_addr  = out_valid ? r_tag[r_rd] : '0;
  assign out_err   = out_valid ? r_errq[r_rd] : 1'b0;
  assign err_count = r_errcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_count  <= 2'd0;
      r_errq   <= 2'b00;
      r_addr   <= RESET_BASE[ADDR_W-1:0];
      r_errcnt <= '0;
    end else begin
      if (w_push) begin
        r_word[r_wr] <= w_word;
        r_tag[r_wr]  <= r_addr;
        r_errq[r_wr] <= w_bad;
        r_wr         <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (load_base)   r_addr <= base_addr;
      else if (w_push) r_addr <= r_addr + ADDR_W'(4);
      if (w_push && w_bad && !(&r_errcnt))
        r_errcnt <= r_errcnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32i_encoder_stream.sv
// Scoreboard bench for rv32i_encoder_stream.
// Driver queues expected head entries; a monitor compares them on every pop.
module tb_rv32i_encoder_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_base = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] a;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr = '0;
  int          exp_errs = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  rv32i_encoder_stream dut (
    .clk(clk), .rst(rst), .load_base(load_base), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word", out_word, e.w);
        check("addr", out_addr, e.a);
        check("err", {31'd0, out_err}, {31'd0, e.e});
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [2:0] f3,
                      input logic alt, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] ew,
                      input logic ee);
    int t;
    exp_t e;
    in_valid = 1'b1; in_class = c; in_funct3 = f3; in_alt = alt;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.w = ee ? 32'h0000_0013 : ew;
    e.a = exp_addr;
    e.e = ee;
    sb.push_back(e);
    exp_addr = exp_addr + 32'd4;
    if (ee && exp_errs < 255) exp_errs++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    exp_addr = '0;
    exp_errs = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 400) begin
      @(posedge clk);
      #1 t++;
    end
    check("drain", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_word", out_word, 32'h0000_0013);
    check("rst_addr", out_addr, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    check("latency", {31'd0, out_valid}, 32'd1);
    drain();

    do_reset();
    send(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,
         32'hFE20_8EE3, 1'b0);
    send(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    send(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(4'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 32'h4033_5293, 1'b0);
    send(4'd9, 3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0010_0073, 1'b0);
    drain();

    do_reset();
    out_ready = 1'b0;
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
    fork
      send(4'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_ready", {31'd0, in_ready}, 32'd0);
          check("bp_head", out_word, 32'h0010_0093);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    do_reset();
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0, 1'b1);
    drain();
    check("errcnt1", {24'd0, err_count}, 32'd1);
    send(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0, 1'b1);
    send(4'd2, 3'd3, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 32'h0, 1'b1);
    send(4'd12, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1'b1);
    drain();
    check("errcnt4", {24'd0, err_count}, 32'd4);
    for (int i = 0; i < 300; i++)
      send(4'd15, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1'b1);
    drain();
    check("errcnt_sat", {24'd0, err_count}, exp_errs[31:0]);
    check("errcnt_255", {24'd0, err_count}, 32'd255);

    do_reset();
    load_base = 1'b1; base_addr = 32'h100;
    in_valid = 1'b1; in_class = 4'd1; in_imm = 32'd7;
    @(negedge clk);
    check("lb_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 load_base = 1'b0; in_valid = 1'b0;
    exp_addr = 32'h100;
    check("lb_nopush", {31'd0, out_valid}, 32'd0);
    send(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,
         32'h1234_52B7, 1'b0);
    drain();
    load_base = 1'b1; base_addr = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 load_base = 1'b0;
    exp_addr = 32'hFFFF_FFFC;
    send(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_1000,
         32'h0000_1097, 1'b0);
    send(4'd6, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4, 32'h0041_00E7, 1'b0);
    drain();

    do_reset();
    out_ready = 1'b0;
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(4'd14, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0, 1'b1);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    check("mid_errcnt", {24'd0, err_count}, 32'd1);
    rst = 1'b1; in_valid = 1'b1; in_class = 4'd1; in_imm = 32'd9;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    exp_addr = '0;
    exp_errs = 0;
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_errcnt", {24'd0, err_count}, 32'd0);
    check("mr_word", out_word, 32'h0000_0013);
    out_ready = 1'b1;
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
